// File: rtl/step_pattern_player_if.sv
// Edit-request channel between the front-panel controller and the pattern player.
//   edit_valid : controller requests an edit
//   edit_ready : player can accept an edit this cycle
//   edit_op    : 00 toggle, 01 set, 10 clear bit, 11 clear whole track
//   edit_track : target track
//   edit_step  : target step (don't care for op 11)
// The master modport is the controller. The slave modport is the player.
interface step_pattern_player_if #(
  parameter int TRACKS = 4
);
  localparam int TW = (TRACKS > 1) ? $clog2(TRACKS) : 1;

  logic          edit_valid;
  logic          edit_ready;
  logic [1:0]    edit_op;
  logic [TW-1:0] edit_track;
  logic [3:0]    edit_step;

  modport master (
    output edit_valid,
    output edit_op,
    output edit_track,
    output edit_step,
    input  edit_ready
  );

  modport slave (
    input  edit_valid,
    input  edit_op,
    input  edit_track,
    input  edit_step,
    output edit_ready
  );
endinterface

// File: rtl/step_pattern_player.sv
// Pattern memory and trigger generator that sits behind the 4-bit step counter.
// It holds a TRACKS x STEPS on/off pattern that the front panel edits.
// Each time a step is entered, every active and unmuted track produces a
// one-cycle hit and a trigger that stays high for PULSE_CYCLES cycles.
// Ports:
//   clk, poweron (async, active-low) : clock and reset
//   step     : current step index coming from the step counter
//   run      : playback enable
//   mute     : per-track mute, sampled only when a step is entered
//   edit     : edit channel (valid/ready, op, track, step)
//   hit      : one-cycle fire pulse per track
//   trig     : stretched trigger per track
//   led_row  : pattern row of edit.edit_track (combinational)
//   playhead : one-hot of the registered step
module step_pattern_player #(
  parameter int TRACKS       = 4,
  parameter int STEPS        = 16,
  parameter int PULSE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   poweron,
  input  logic [3:0]             step,
  input  logic                   run,
  input  logic [TRACKS-1:0]      mute,
  step_pattern_player_if.slave   edit,
  output logic [TRACKS-1:0]      hit,
  output logic [TRACKS-1:0]      trig,
  output logic [STEPS-1:0]       led_row,
  output logic [STEPS-1:0]       playhead
);

  localparam int TW = (TRACKS > 1) ? $clog2(TRACKS) : 1;
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam int IW = $clog2(STEPS);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);

  localparam logic [1:0] OP_TOGGLE  = 2'b00;
  localparam logic [1:0] OP_SET     = 2'b01;
  localparam logic [1:0] OP_CLR     = 2'b10;
  localparam logic [1:0] OP_CLR_TRK = 2'b11;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // Decrement that holds at zero.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  // New value of one pattern bit for a single-bit edit.
  function automatic logic bit_next(input logic [1:0] op, input logic b);
    case (op)
      OP_TOGGLE: return ~b;
      OP_SET:    return 1'b1;
      OP_CLR:    return 1'b0;
      default:   return b;
    endcase
  endfunction

  logic [3:0]        step_q;
  logic              run_q;
  logic [TRACKS-1:0] hit_q;
  logic [TRACKS-1:0] fire_d;
  logic [CW-1:0]     cnt_q [TRACKS];
  logic [STEPS-1:0]  pat_q [TRACKS];
  state_t            state_q;
  logic              ready_q;
  logic [TW-1:0]     clr_trk_q;
  logic [IW-1:0]     clr_idx_q;
  logic              entry;

  // A step is entered when the step index changes while running, or when run
  // rises. This lets starting playback fire the step that is already current.
  assign entry = run && ((step != step_q) || !run_q);

  // Fire decisions read the pattern as it was before this edge, so an edit
  // that commits on the same edge does not affect the current entry.
  always_comb begin
    fire_d = '0;
    for (int t = 0; t < TRACKS; t++) begin
      fire_d[t] = entry & pat_q[t][step] & ~mute[t];
    end
  end

  // Playback: step/run history, hit pulses and the per-track trigger counters.
  // The counter is reloaded on the same edge that raises hit, so trig and
  // hit go high together. A reload takes priority over the decrement.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      step_q <= '0;
      run_q  <= 1'b0;
      hit_q  <= '0;
      for (int t = 0; t < TRACKS; t++) cnt_q[t] <= '0;
    end else begin
      step_q <= step;
      run_q  <= run;
      hit_q  <= fire_d;
      for (int t = 0; t < TRACKS; t++) begin
        cnt_q[t] <= fire_d[t] ? PULSE_LD : sat_dec(cnt_q[t]);
      end
    end
  end

  always_comb begin
    trig = '0;
    for (int t = 0; t < TRACKS; t++) trig[t] = (cnt_q[t] != '0);
  end

  // Edit FSM together with the pattern array.
  // Track indices that are out of range never match a row. Such edits are
  // accepted but change nothing. ready_q stays low during reset and rises
  // on the first edge after reset is released.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      clr_trk_q <= '0;
      clr_idx_q <= '0;
      for (int t = 0; t < TRACKS; t++) pat_q[t] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (edit.edit_valid && ready_q) begin
            if (edit.edit_op == OP_CLR_TRK) begin
              state_q   <= S_CLEAR;
              ready_q   <= 1'b0;
              clr_trk_q <= edit.edit_track;
              clr_idx_q <= '0;
            end else begin
              for (int t = 0; t < TRACKS; t++) begin
                if (int'(edit.edit_track) == t) begin
                  pat_q[t][edit.edit_step] <= bit_next(edit.edit_op, pat_q[t][edit.edit_step]);
                end
              end
            end
          end
        end
        S_CLEAR: begin
          // Clear one bit per cycle. Playback keeps reading the row while it
          // is only partly cleared.
          for (int t = 0; t < TRACKS; t++) begin
            if (int'(clr_trk_q) == t) pat_q[t][clr_idx_q] <= 1'b0;
          end
          clr_idx_q <= clr_idx_q + IW'(1);
          if (clr_idx_q == IW'(STEPS - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign edit.edit_ready = ready_q;
  assign hit             = hit_q;
  assign playhead        = STEPS'(1) << step_q;

  always_comb begin
    led_row = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (int'(edit.edit_track) == t) led_row = pat_q[t];
    end
  end

endmodule

// File: tb/tb_step_pattern_player.sv
module tb_step_pattern_player;

  localparam int TRACKS = 4;
  localparam int STEPS  = 16;
  localparam int PULSE  = 10;

  logic              clk = 1'b0;
  logic              poweron;
  logic [3:0]        step;
  logic              run;
  logic [TRACKS-1:0] mute;
  logic [TRACKS-1:0] hit;
  logic [TRACKS-1:0] trig;
  logic [STEPS-1:0]  led_row;
  logic [STEPS-1:0]  playhead;

  int total = 0;
  int bad   = 0;

  step_pattern_player_if #(.TRACKS(TRACKS)) edit_if ();

  step_pattern_player #(
    .TRACKS(TRACKS), .STEPS(STEPS), .PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk), .poweron(poweron), .step(step), .run(run), .mute(mute),
    .edit(edit_if), .hit(hit), .trig(trig), .led_row(led_row), .playhead(playhead)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_edit(input logic [1:0] op, input int trk, input int stp);
    edit_if.edit_op    = op;
    edit_if.edit_track = 2'(trk);
    edit_if.edit_step  = 4'(stp);
    edit_if.edit_valid = 1'b1;
    tick();
    edit_if.edit_valid = 1'b0;
  endtask

  int trig_cnt, extra_hit, other_cnt, low_cnt;

  initial begin
    poweron = 1'b0; step = 4'd0; run = 1'b0; mute = '0;
    edit_if.edit_valid = 1'b0; edit_if.edit_op = 2'b00;
    edit_if.edit_track = '0;   edit_if.edit_step = 4'd0;

    // Values while reset is held, then after release.
    #12;
    check("rst_hit", hit, 0);
    check("rst_trig", trig, 0);
    check("rst_ready", edit_if.edit_ready, 0);
    check("rst_playhead", playhead, 16'h0001);
    check("rst_led", led_row, 16'h0000);
    poweron = 1'b1;
    tick();
    check("rel_ready", edit_if.edit_ready, 1);

    // Load patterns with run=0.
    for (int s = 0; s < 16; s += 4) do_edit(2'b01, 0, s);
    for (int s = 0; s < 16; s++) begin
      do_edit(2'b01, 1, s);
      do_edit(2'b01, 2, s);
      do_edit(2'b01, 3, s);
    end
    edit_if.edit_track = 2'd0; #1;
    check("led_t0", led_row, 16'h1111);
    do_edit(2'b10, 1, 3);
    check("led_t1_clr", led_row, 16'hFFF7);
    do_edit(2'b00, 1, 3);
    check("led_t1_tog", led_row, 16'hFFFF);
    check("idle_hit", hit, 0);

    // Sweep with only track 0 unmuted, one step every 100 cycles.
    mute = 4'b1110; extra_hit = 0; other_cnt = 0;
    for (int s = 0; s < 16; s++) begin
      step = 4'(s); run = 1'b1; trig_cnt = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (i == 0) check("sweep_hit", hit, (s % 4 == 0) ? 4'b0001 : 4'b0000);
        else if (hit != 0) extra_hit++;
        if (trig[0]) trig_cnt++;
        if (hit[3:1] != 0 || trig[3:1] != 0) other_cnt++;
      end
      check("sweep_trig_len", trig_cnt, (s % 4 == 0) ? PULSE : 0);
    end
    check("sweep_extra_hit", extra_hit, 0);
    check("sweep_other_tracks", other_cnt, 0);

    // Retrigger on track 1 every 4 cycles keeps trig high with no gap.
    mute = 4'b1101; trig_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step = 4'(k);
      tick();
      check("rt_hit", hit, 4'b0010);
      if (trig[1]) trig_cnt++;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (trig[1]) trig_cnt++;
      end
    end
    check("rt_cont", trig_cnt, 32);
    repeat (6) tick();
    check("rt_tail_hi", trig[1], 1);
    tick();
    check("rt_tail_lo", trig[1], 0);

    // Muted track 2 stays silent. It fires once unmuted. Mid-pulse mute and run=0 leave trig running.
    mute = 4'b1111;
    for (int s = 1; s <= 4; s++) begin
      step = 4'(s);
      tick();
      check("mute_hit", hit, 0);
      tick();
      check("mute_trig", trig, 0);
    end
    mute = 4'b1011; step = 4'd5;
    tick();
    check("unmute_hit", hit, 4'b0100);
    check("unmute_trig", trig, 4'b0100);
    mute = 4'b1111;
    repeat (3) tick();
    check("mute_mid_pulse", trig, 4'b0100);
    run = 1'b0; step = 4'd6;
    tick();
    check("run0_hit", hit, 0);
    check("run0_trig_keep", trig, 4'b0100);
    repeat (5) tick();
    check("run0_trig_last", trig, 4'b0100);
    tick();
    check("run0_drain", trig, 0);

    // Clear track 3 while playing, with a second edit held waiting.
    mute = 4'b0111; step = 4'd6; run = 1'b1;
    repeat (12) tick();
    check("clr_ready_pre", edit_if.edit_ready, 1);
    edit_if.edit_op = 2'b11; edit_if.edit_track = 2'd3; edit_if.edit_valid = 1'b1;
    tick();
    edit_if.edit_op = 2'b01; edit_if.edit_step = 4'd2;
    check("clr_ready_low", edit_if.edit_ready, 0);
    low_cnt = 0;
    for (int i = 0; i < 40 && edit_if.edit_ready == 1'b0; i++) begin
      if (i == 2) step = 4'd10;
      if (i == 8) step = 4'd1;
      tick();
      low_cnt++;
      if (i == 2) check("clr_hit_uncleared", hit, 4'b1000);
      if (i == 8) check("clr_hit_cleared", hit, 4'b0000);
    end
    check("clr_low_cycles", low_cnt, 16);
    check("clr_led_zero", led_row, 16'h0000);
    tick();
    edit_if.edit_valid = 1'b0;
    check("clr_held_edit", led_row, 16'h0004);

    // Toggle on the same cycle as the entry uses the old bit.
    mute = 4'b1110; edit_if.edit_track = 2'd0;
    repeat (12) tick();
    step = 4'd7;
    edit_if.edit_op = 2'b00; edit_if.edit_step = 4'd7; edit_if.edit_valid = 1'b1;
    tick();
    edit_if.edit_valid = 1'b0;
    check("tog_same_hit", hit, 0);
    check("tog_led", led_row, 16'h1191);
    step = 4'd15;
    tick();
    check("tog_s15_hit", hit, 0);
    step = 4'd0;
    tick();
    check("wrap_hit", hit, 4'b0001);
    step = 4'd7;
    tick();
    check("tog_next_hit", hit, 4'b0001);

    // Reset while a trigger is active and a track clear is in progress.
    edit_if.edit_op = 2'b11; edit_if.edit_track = 2'd1; edit_if.edit_valid = 1'b1;
    tick();
    edit_if.edit_valid = 1'b0;
    repeat (3) tick();
    check("pre_rst_trig", trig[0], 1);
    check("pre_rst_ready", edit_if.edit_ready, 0);
    #2 poweron = 1'b0;
    #1;
    check("arst_hit", hit, 0);
    check("arst_trig", trig, 0);
    check("arst_ready", edit_if.edit_ready, 0);
    check("arst_playhead", playhead, 16'h0001);
    for (int t = 0; t < TRACKS; t++) begin
      edit_if.edit_track = 2'(t);
      #1;
      check("arst_led", led_row, 16'h0000);
    end
    poweron = 1'b1;
    tick();
    check("arel_ready", edit_if.edit_ready, 1);
    check("arel_playhead", playhead, 16'h0080);
    check("arel_hit", hit, 0);
    check("arel_trig", trig, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
